// File: rtl/sprite_dma_engine.sv
// sprite_dma_engine
//
// Copies the CPU-side sprite RAM (OBJ) into the sprite-renderer buffer when
// the address decoder fires its sprite_dma strobe. The renderer then works
// from a stable frame snapshot while the CPU rewrites its own copy.
// One word moves per clock-enabled cycle.
//
// Parameters
//   WORDS        number of 16-bit words per transfer (power of two, 2..1024)
//   AW           address width, log2(WORDS)
//   WAIT_VBLANK  1: a pending request waits in ARM for vblank; 0: starts at once
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   ce        in   clock enable; state advances only when ce=1
//   dma_req   in   one-clk request strobe, sampled every clk regardless of ce
//   vblank    in   vertical blank, only looked at in ARM
//   src_addr  out  sprite RAM read address
//   src_data  in   sprite RAM read data, one clk registered latency
//   dst_addr  out  buffer write address
//   dst_data  out  buffer write data
//   dst_we    out  buffer write strobe, only ever high in ce cycles
//   busy      out  high from transfer start until the last write
//   done      out  one-clk pulse in the cycle after the last write

module sprite_dma_engine #(
  parameter int WORDS       = 512,
  parameter int AW          = 9,
  parameter bit WAIT_VBLANK = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          dma_req,
  input  logic          vblank,
  output logic [AW-1:0] src_addr,
  input  logic [15:0]   src_data,
  output logic [AW-1:0] dst_addr,
  output logic [15:0]   dst_data,
  output logic          dst_we,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COPY  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_addr_q, src_addr_d;
  logic          pending_q, pending_d;
  logic          done_q, done_d;
  logic          enter_copy;
  logic          copy_wr;
  logic          flush_wr;

  // State register. Reset aborts any transfer on the spot; the buffer simply
  // keeps whatever was already written and no done pulse is produced.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      src_addr_q <= '0;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_addr_q <= src_addr_d;
      pending_q  <= pending_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic. src_addr runs one word ahead of the write side because
  // the sprite RAM read is registered: the first COPY cycle only primes the
  // read, and FLUSH drains the final word once src_addr has stopped at the
  // last address (it holds there rather than wrapping).
  always_comb begin
    state_d    = state_q;
    src_addr_d = src_addr_q;
    done_d     = 1'b0;
    enter_copy = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ce && pending_q) begin
          if (WAIT_VBLANK) begin
            state_d = ARM;
          end else begin
            state_d    = COPY;
            src_addr_d = '0;
            enter_copy = 1'b1;
          end
        end
      end

      ARM: begin
        if (ce && vblank) begin
          state_d    = COPY;
          src_addr_d = '0;
          enter_copy = 1'b1;
        end
      end

      COPY: begin
        if (ce) begin
          if (src_addr_q == LAST_ADDR) begin
            state_d = FLUSH;
          end else begin
            src_addr_d = src_addr_q + AW'(1);
          end
        end
      end

      FLUSH: begin
        if (ce) begin
          state_d    = IDLE;
          src_addr_d = '0;
          done_d     = 1'b1;
        end
      end

      default: begin
        state_d    = IDLE;
        src_addr_d = '0;
      end
    endcase
  end

  // A single pending flag: any number of requests before COPY begins collapse
  // into one transfer. A request arriving in the same clk as COPY entry is
  // kept, because it came in after the transfer it would otherwise merge with
  // had already been committed.
  always_comb begin
    pending_d = dma_req | (pending_q & ~enter_copy);
  end

  // Write side. In COPY the word on src_data belongs to the previous address;
  // src_addr is zero only in the priming cycle, so that cycle writes nothing.
  always_comb begin
    copy_wr  = (state_q == COPY) && (src_addr_q != '0);
    flush_wr = (state_q == FLUSH);

    dst_we   = ce & (copy_wr | flush_wr);
    dst_data = (copy_wr | flush_wr) ? src_data : 16'h0000;

    if (flush_wr) begin
      dst_addr = src_addr_q;
    end else if (copy_wr) begin
      dst_addr = src_addr_q - AW'(1);
    end else begin
      dst_addr = '0;
    end
  end

  assign src_addr = src_addr_q;
  assign busy     = (state_q == COPY) || (state_q == FLUSH);
  assign done     = done_q;

endmodule

// File: tb/tb_sprite_dma_engine.sv
// tb_sprite_dma_engine
//
// Three engines share the clock, reset and ce:
//   u_main  WORDS=512, immediate start  (full copies, ce gaps, re-request, reset)
//   u_vb    WORDS=8,   waits for vblank
//   u_small WORDS=2    (address sequence and request merging)
// Each engine reads from a registered sprite RAM model whose contents are
// addr ^ key. Expected buffer writes are queued by the stimulus; a monitor
// pops and compares them whenever the DUT strobes dst_we.

module tb_sprite_dma_engine;

  logic clk = 1'b0;
  logic reset;
  logic ce;

  logic        dma_req_m, vblank_m;
  logic [8:0]  src_addr_m, dst_addr_m;
  logic [15:0] src_data_m, dst_data_m;
  logic        dst_we_m, busy_m, done_m;

  logic        dma_req_v, vblank_v;
  logic [2:0]  src_addr_v, dst_addr_v;
  logic [15:0] src_data_v, dst_data_v;
  logic        dst_we_v, busy_v, done_v;

  logic        dma_req_s, vblank_s;
  logic [0:0]  src_addr_s, dst_addr_s;
  logic [15:0] src_data_s, dst_data_s;
  logic        dst_we_s, busy_s, done_s;

  logic [15:0] key_m = 16'hA5A5;
  logic [15:0] key_v = 16'h1234;
  logic [15:0] key_s = 16'h0F0F;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int ce_mode = 0;

  int wr_m = 0, wr_v = 0, wr_s = 0;
  int done_m_total = 0, done_v_total = 0, done_s_total = 0;
  int busy_m_total = 0;
  int last_done_m = 0;

  logic [31:0] exp_m[$];
  logic [31:0] exp_v[$];
  logic [31:0] exp_s[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered sprite RAM models
  always @(posedge clk) begin
    src_data_m <= 16'(src_addr_m) ^ key_m;
    src_data_v <= 16'(src_addr_v) ^ key_v;
    src_data_s <= 16'(src_addr_s) ^ key_s;
  end

  sprite_dma_engine #(.WORDS(512), .AW(9), .WAIT_VBLANK(1'b0)) u_main (
    .clk(clk), .reset(reset), .ce(ce), .dma_req(dma_req_m), .vblank(vblank_m),
    .src_addr(src_addr_m), .src_data(src_data_m), .dst_addr(dst_addr_m),
    .dst_data(dst_data_m), .dst_we(dst_we_m), .busy(busy_m), .done(done_m)
  );

  sprite_dma_engine #(.WORDS(8), .AW(3), .WAIT_VBLANK(1'b1)) u_vb (
    .clk(clk), .reset(reset), .ce(ce), .dma_req(dma_req_v), .vblank(vblank_v),
    .src_addr(src_addr_v), .src_data(src_data_v), .dst_addr(dst_addr_v),
    .dst_data(dst_data_v), .dst_we(dst_we_v), .busy(busy_v), .done(done_v)
  );

  sprite_dma_engine #(.WORDS(2), .AW(1), .WAIT_VBLANK(1'b0)) u_small (
    .clk(clk), .reset(reset), .ce(ce), .dma_req(dma_req_s), .vblank(vblank_s),
    .src_addr(src_addr_s), .src_data(src_data_s), .dst_addr(dst_addr_s),
    .dst_data(dst_data_s), .dst_we(dst_we_s), .busy(busy_s), .done(done_s)
  );

  // One comparison: count it, and report it only when it goes wrong
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic noteExtraWrite(input string name, input logic [31:0] actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got write 0x%0h, expected no write", name, actual);
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!ce) begin
        checkOutput("we_gated_m", {31'd0, dst_we_m}, 32'd0);
        checkOutput("we_gated_v", {31'd0, dst_we_v}, 32'd0);
        checkOutput("we_gated_s", {31'd0, dst_we_s}, 32'd0);
      end
      if (dst_we_m) begin
        wr_m++;
        if (exp_m.size() == 0) noteExtraWrite("extra_write_m", {7'd0, dst_addr_m, dst_data_m});
        else begin
          e = exp_m.pop_front();
          checkOutput("write_m", {7'd0, dst_addr_m, dst_data_m}, e);
        end
      end
      if (dst_we_v) begin
        wr_v++;
        if (exp_v.size() == 0) noteExtraWrite("extra_write_v", {13'd0, dst_addr_v, dst_data_v});
        else begin
          e = exp_v.pop_front();
          checkOutput("write_v", {13'd0, dst_addr_v, dst_data_v}, e);
        end
      end
      if (dst_we_s) begin
        wr_s++;
        if (exp_s.size() == 0) noteExtraWrite("extra_write_s", {15'd0, dst_addr_s, dst_data_s});
        else begin
          e = exp_s.pop_front();
          checkOutput("write_s", {15'd0, dst_addr_s, dst_data_s}, e);
        end
      end
      if (busy_m) busy_m_total++;
      if (done_m) begin
        done_m_total++;
        last_done_m = cyc;
      end
      if (done_v) done_v_total++;
      if (done_s) done_s_total++;
    end
  end

  // Advance one clock; inputs change just after the falling edge
  task automatic tick();
    @(negedge clk);
    #1;
    if (ce_mode == 1) ce = ~ce;
    else if (ce_mode == 2) ce = 1'b0;
    else ce = 1'b1;
  endtask

  task automatic pulseMain(output int r);
    dma_req_m = 1'b1;
    tick();
    r = cyc;
    dma_req_m = 1'b0;
  endtask

  task automatic pushMain(input logic [15:0] key);
    for (int i = 0; i < 512; i++) exp_m.push_back({16'(i), 16'(i) ^ key});
  endtask

  // One full main-engine transfer, ce steady or toggling every clk
  task automatic applyStimulus(input bit toggle, input logic [15:0] key, input string tag);
    int d0, b0, w0, r, n;
    ce_mode = toggle ? 1 : 0;
    key_m = key;
    pushMain(key);
    d0 = done_m_total;
    b0 = busy_m_total;
    w0 = wr_m;
    pulseMain(r);
    n = 0;
    while (done_m_total == d0 && n < 3000) begin
      tick();
      n++;
    end
    checkOutput({tag, "_done_seen"}, 32'(done_m_total - d0), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    if (!toggle) checkOutput({tag, "_latency"}, 32'(last_done_m - r), 32'd514);
    checkOutput({tag, "_busy_len"}, 32'(busy_m_total - b0), toggle ? 32'd1026 : 32'd513);
    checkOutput({tag, "_writes"}, 32'(wr_m - w0), 32'd512);
    checkOutput({tag, "_done_count"}, 32'(done_m_total - d0), 32'd1);
    checkOutput({tag, "_queue_empty"}, 32'(exp_m.size()), 32'd0);
    ce_mode = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r, n, d0, w0;
    reset = 1'b1;
    ce = 1'b1;
    dma_req_m = 1'b0; vblank_m = 1'b0;
    dma_req_v = 1'b0; vblank_v = 1'b0;
    dma_req_s = 1'b0; vblank_s = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Reset state
    checkOutput("rst_busy", {31'd0, busy_m}, 32'd0);
    checkOutput("rst_we", {31'd0, dst_we_m}, 32'd0);
    checkOutput("rst_done", {31'd0, done_m}, 32'd0);
    checkOutput("rst_src_addr", 32'(src_addr_m), 32'd0);
    checkOutput("rst_dst_addr", 32'(dst_addr_m), 32'd0);
    checkOutput("rst_dst_data", 32'(dst_data_m), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    $display("[TB] full copy, ce=1");
    applyStimulus(1'b0, 16'hA5A5, "full");

    $display("[TB] full copy, ce toggling");
    applyStimulus(1'b1, 16'h5A5A, "toggle");

    $display("[TB] second request at write 100");
    key_m = 16'h3C3C;
    pushMain(16'h3C3C);
    d0 = done_m_total;
    w0 = wr_m;
    pulseMain(r);
    n = 0;
    while (wr_m - w0 < 100 && n < 1000) begin
      tick();
      n++;
    end
    checkOutput("rereq_reach_100", 32'(wr_m - w0), 32'd100);
    pushMain(16'h3C3C);
    pulseMain(r);
    n = 0;
    while (done_m_total - d0 < 2 && n < 3000) begin
      tick();
      n++;
    end
    for (int i = 0; i < 4; i++) tick();
    checkOutput("rereq_done_count", 32'(done_m_total - d0), 32'd2);
    checkOutput("rereq_writes", 32'(wr_m - w0), 32'd1024);
    checkOutput("rereq_queue_empty", 32'(exp_m.size()), 32'd0);

    $display("[TB] reset at write 300");
    key_m = 16'h0FF0;
    pushMain(16'h0FF0);
    d0 = done_m_total;
    w0 = wr_m;
    pulseMain(r);
    n = 0;
    while (wr_m - w0 < 300 && n < 1000) begin
      tick();
      n++;
    end
    checkOutput("abort_reach_300", 32'(wr_m - w0), 32'd300);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort_busy", {31'd0, busy_m}, 32'd0);
    checkOutput("abort_we", {31'd0, dst_we_m}, 32'd0);
    checkOutput("abort_src_addr", 32'(src_addr_m), 32'd0);
    exp_m.delete();
    for (int i = 0; i < 6; i++) tick();
    checkOutput("abort_no_done", 32'(done_m_total - d0), 32'd0);
    applyStimulus(1'b0, 16'h0FF0, "after_reset");

    $display("[TB] vblank-gated start");
    for (int i = 0; i < 8; i++) exp_v.push_back({16'(i), 16'(i) ^ key_v});
    d0 = done_v_total;
    dma_req_v = 1'b1;
    tick();
    dma_req_v = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      checkOutput("arm_busy_low", {31'd0, busy_v}, 32'd0);
    end
    w0 = wr_v;
    vblank_v = 1'b1;
    tick();
    checkOutput("vb_busy_rise", {31'd0, busy_v}, 32'd1);
    checkOutput("vb_no_write_yet", 32'(wr_v - w0), 32'd0);
    tick();
    checkOutput("vb_first_write", 32'(wr_v - w0), 32'd1);
    vblank_v = 1'b0;
    n = 0;
    while (done_v_total == d0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    checkOutput("vb_done_count", 32'(done_v_total - d0), 32'd1);
    checkOutput("vb_writes", 32'(wr_v - w0), 32'd8);
    checkOutput("vb_queue_empty", 32'(exp_v.size()), 32'd0);

    $display("[TB] two-word engine sequence");
    exp_s.push_back({16'd0, 16'h0F0F});
    exp_s.push_back({16'd1, 16'h0F0E});
    d0 = done_s_total;
    w0 = wr_s;
    dma_req_s = 1'b1;
    tick();
    dma_req_s = 1'b0;
    n = 0;
    while (!busy_s && n < 20) begin
      tick();
      n++;
    end
    checkOutput("s_seq0", 32'(src_addr_s), 32'd0);
    tick();
    checkOutput("s_seq1", 32'(src_addr_s), 32'd1);
    tick();
    checkOutput("s_seq2", 32'(src_addr_s), 32'd1);
    checkOutput("s_done_early", {31'd0, done_s}, 32'd0);
    tick();
    checkOutput("s_done_4th", {31'd0, done_s}, 32'd1);
    tick();
    checkOutput("s_writes", 32'(wr_s - w0), 32'd2);
    checkOutput("s_queue_empty", 32'(exp_s.size()), 32'd0);

    $display("[TB] requests merged while ce=0");
    exp_s.push_back({16'd0, 16'h0F0F});
    exp_s.push_back({16'd1, 16'h0F0E});
    d0 = done_s_total;
    w0 = wr_s;
    ce_mode = 2;
    ce = 1'b0;
    dma_req_s = 1'b1;
    tick();
    dma_req_s = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    dma_req_s = 1'b1;
    tick();
    dma_req_s = 1'b0;
    tick();
    checkOutput("merge_stalled", {31'd0, busy_s}, 32'd0);
    ce_mode = 0;
    for (int i = 0; i < 12; i++) tick();
    checkOutput("merge_done_count", 32'(done_s_total - d0), 32'd1);
    checkOutput("merge_writes", 32'(wr_s - w0), 32'd2);
    checkOutput("merge_queue_empty", 32'(exp_s.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
